// File: rtl/ina219_i2c_model.sv
// INA219 current/power monitor modelled as an open-drain I2C slave with digital measurement inputs.
// Define INA219_CALC_EN to build the current/power calculation datapath (registers 0x03/0x04).
module ina219_i2c_model #(
    parameter logic [6:0]  SLV_ADDR = 7'h01,
    parameter logic [15:0] CFG_RST  = 16'h399F
) (
    input  logic        clock,
    input  logic        rst,
    inout  wire         sda,
    input  logic        scl,
    input  logic [15:0] test_in_voltage,
    input  logic [15:0] test_in_shunt
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK, ST_WR_MSB, ST_WR_MSB_ACK,
        ST_WR_LSB, ST_WR_LSB_ACK, ST_RD_MSB, ST_RD_MSB_ACK, ST_RD_LSB, ST_RD_LSB_ACK, ST_IGNORE
    } state_t;

    state_t      state_r, state_next_s;
    logic [1:0]  scl_sync_r, sda_sync_r;
    logic        scl_d_r, sda_d_r;
    logic        scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
    logic        rx_state_s, tx_state_s;
    logic [3:0]  bit_cnt_r;
    logic [7:0]  shift_r, tx_r, wr_msb_r;
    logic [2:0]  ptr_r;
    logic        rw_r, mack_r, wr_done_r, drive_r, drive_next_s;
    logic        ld_ptr_s, ld_msb_s, commit_s, snap_ld_s, ld_tx_msb_s, ld_tx_lsb_s, tx_shift_s;
    logic [15:0] snap_r, cfg_r, cal_r, shunt_r, bus_r;
    logic [15:0] rd_val_s, cur_val_s, pwr_val_s;
    logic signed [15:0] shunt_in_s, shunt_lim_s, shunt_clamp_s;
    logic        shunt_ovf_s, bus_ovf_s;
    logic [12:0] bus_lim_s, bd_s;

    assign sda        = drive_r ? 1'b0 : 1'bz;
    assign scl_s      = scl_sync_r[1];
    assign sda_s      = sda_sync_r[1];
    assign scl_rise_s = scl_s & ~scl_d_r;
    assign scl_fall_s = ~scl_s & scl_d_r;
    assign start_s    = scl_s & scl_d_r & sda_d_r & ~sda_s;
    assign stop_s     = scl_s & scl_d_r & ~sda_d_r & sda_s;
    assign rx_state_s = (state_r == ST_ADDR) || (state_r == ST_PTR) ||
                        (state_r == ST_WR_MSB) || (state_r == ST_WR_LSB);
    assign tx_state_s = (state_r == ST_RD_MSB) || (state_r == ST_RD_LSB);

    // Two-flop synchronizers and one-cycle history for edge/condition detection.
    always_ff @(posedge clock) begin
        if (rst) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl};
            sda_sync_r <= {sda_sync_r[0], sda};
            scl_d_r    <= scl_s;
            sda_d_r    <= sda_s;
        end
    end

    // Protocol FSM: next state, next SDA drive and datapath load strobes.
    always_comb begin
        state_next_s = state_r;
        drive_next_s = drive_r;
        ld_ptr_s     = 1'b0;
        ld_msb_s     = 1'b0;
        commit_s     = 1'b0;
        snap_ld_s    = 1'b0;
        ld_tx_msb_s  = 1'b0;
        ld_tx_lsb_s  = 1'b0;
        tx_shift_s   = 1'b0;
        if (start_s) begin
            state_next_s = ST_ADDR;
            drive_next_s = 1'b0;
        end else if (stop_s) begin
            state_next_s = ST_IDLE;
            drive_next_s = 1'b0;
        end else if (scl_fall_s) begin
            case (state_r)
                ST_ADDR: begin
                    if (bit_cnt_r != 4'd8) begin
                        state_next_s = ST_ADDR;
                    end else if (shift_r[7:1] == SLV_ADDR) begin
                        state_next_s = ST_ADDR_ACK;
                        drive_next_s = 1'b1;
                        snap_ld_s    = shift_r[0];
                    end else begin
                        state_next_s = ST_IGNORE;
                    end
                end
                ST_ADDR_ACK: begin
                    if (rw_r) begin
                        state_next_s = ST_RD_MSB;
                        drive_next_s = ~snap_r[15];
                        ld_tx_msb_s  = 1'b1;
                    end else begin
                        state_next_s = ST_PTR;
                        drive_next_s = 1'b0;
                    end
                end
                ST_PTR: begin
                    if (bit_cnt_r == 4'd8) begin
                        state_next_s = ST_PTR_ACK;
                        drive_next_s = 1'b1;
                        ld_ptr_s     = 1'b1;
                    end else begin
                        state_next_s = ST_PTR;
                    end
                end
                ST_PTR_ACK: begin
                    state_next_s = ST_WR_MSB;
                    drive_next_s = 1'b0;
                end
                ST_WR_MSB: begin
                    if (bit_cnt_r == 4'd8) begin
                        state_next_s = ST_WR_MSB_ACK;
                        drive_next_s = 1'b1;
                        ld_msb_s     = 1'b1;
                    end else begin
                        state_next_s = ST_WR_MSB;
                    end
                end
                ST_WR_MSB_ACK: begin
                    state_next_s = ST_WR_LSB;
                    drive_next_s = 1'b0;
                end
                ST_WR_LSB: begin
                    if (bit_cnt_r == 4'd8) begin
                        state_next_s = ST_WR_LSB_ACK;
                        drive_next_s = 1'b1;
                        commit_s     = ~wr_done_r;
                    end else begin
                        state_next_s = ST_WR_LSB;
                    end
                end
                ST_WR_LSB_ACK: begin
                    // Further bytes come back through WR_LSB, acknowledged but never committed.
                    state_next_s = ST_WR_LSB;
                    drive_next_s = 1'b0;
                end
                ST_RD_MSB, ST_RD_LSB: begin
                    if (bit_cnt_r == 4'd7) begin
                        state_next_s = (state_r == ST_RD_MSB) ? ST_RD_MSB_ACK : ST_RD_LSB_ACK;
                        drive_next_s = 1'b0;
                    end else begin
                        drive_next_s = ~tx_r[6];
                        tx_shift_s   = 1'b1;
                    end
                end
                ST_RD_MSB_ACK: begin
                    if (mack_r) begin
                        state_next_s = ST_RD_LSB;
                        drive_next_s = ~snap_r[7];
                        ld_tx_lsb_s  = 1'b1;
                    end else begin
                        state_next_s = ST_IGNORE;
                        drive_next_s = 1'b0;
                    end
                end
                ST_RD_LSB_ACK: begin
                    if (mack_r) begin
                        state_next_s = ST_RD_MSB;
                        drive_next_s = ~snap_r[15];
                        ld_tx_msb_s  = 1'b1;
                    end else begin
                        state_next_s = ST_IGNORE;
                        drive_next_s = 1'b0;
                    end
                end
                default: begin
                    state_next_s = state_r;
                    drive_next_s = 1'b0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM state register and bit-level shift/transmit datapath.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            drive_r   <= 1'b0;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            tx_r      <= 8'h00;
            wr_msb_r  <= 8'h00;
            snap_r    <= 16'h0000;
            ptr_r     <= 3'd0;
            rw_r      <= 1'b0;
            mack_r    <= 1'b0;
            wr_done_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            drive_r <= drive_next_s;
            if (start_s || (state_next_s != state_r)) begin
                bit_cnt_r <= 4'd0;
            end else if ((scl_rise_s && rx_state_s) || (scl_fall_s && tx_state_s)) begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
            end
            if (scl_rise_s) begin
                shift_r <= {shift_r[6:0], sda_s};
            end
            if (state_r == ST_ADDR) begin
                rw_r <= shift_r[0];
            end
            if (scl_rise_s && ((state_r == ST_RD_MSB_ACK) || (state_r == ST_RD_LSB_ACK))) begin
                mack_r <= ~sda_s;
            end
            if (snap_ld_s) begin
                snap_r <= rd_val_s;
            end
            if (ld_tx_msb_s) begin
                tx_r <= snap_r[15:8];
            end else if (ld_tx_lsb_s) begin
                tx_r <= snap_r[7:0];
            end else if (tx_shift_s) begin
                tx_r <= {tx_r[6:0], 1'b0};
            end
            if (ld_ptr_s) begin
                ptr_r <= shift_r[2:0];
            end
            if (ld_msb_s) begin
                wr_msb_r <= shift_r;
            end
            if (start_s) begin
                wr_done_r <= 1'b0;
            end else if (commit_s) begin
                wr_done_r <= 1'b1;
            end
        end
    end

    // Shunt and bus saturation limits selected by the current configuration.
    always_comb begin
        shunt_in_s = $signed(test_in_shunt);
        case (cfg_r[12:11])
            2'b00:   shunt_lim_s = 16'sd4000;
            2'b01:   shunt_lim_s = 16'sd8000;
            2'b10:   shunt_lim_s = 16'sd16000;
            default: shunt_lim_s = 16'sd32000;
        endcase
        if (shunt_in_s > shunt_lim_s) begin
            shunt_clamp_s = shunt_lim_s;
            shunt_ovf_s   = 1'b1;
        end else if (shunt_in_s < -shunt_lim_s) begin
            shunt_clamp_s = -shunt_lim_s;
            shunt_ovf_s   = 1'b1;
        end else begin
            shunt_clamp_s = shunt_in_s;
            shunt_ovf_s   = 1'b0;
        end
        bus_lim_s = cfg_r[13] ? 13'd8000 : 13'd4000;
        bus_ovf_s = test_in_voltage > {3'b000, bus_lim_s};
        bd_s      = bus_ovf_s ? bus_lim_s : test_in_voltage[12:0];
    end

    // Register file: config/calibration writes and per-clock measurement capture.
    always_ff @(posedge clock) begin
        if (rst) begin
            cfg_r   <= CFG_RST & 16'h7FFF;
            cal_r   <= 16'h0000;
            shunt_r <= 16'h0000;
            bus_r   <= 16'h0000;
        end else begin
            shunt_r <= shunt_clamp_s;
            bus_r   <= {bd_s, 1'b0, 1'b1, shunt_ovf_s | bus_ovf_s};
            if (commit_s) begin
                case (ptr_r)
                    3'd0: begin
                        if (wr_msb_r[7]) begin
                            cfg_r <= CFG_RST & 16'h7FFF;
                            cal_r <= 16'h0000;
                        end else begin
                            cfg_r <= {1'b0, wr_msb_r[6:0], shift_r};
                        end
                    end
                    3'd5:    cal_r <= {wr_msb_r, shift_r[7:1], 1'b0};
                    default: cfg_r <= cfg_r;
                endcase
            end
        end
    end

`ifdef INA219_CALC_EN
    logic signed [33:0] cur_prod_s;
    logic signed [21:0] cur_shift_s;
    logic [16:0]        cur_abs_s;
    logic [29:0]        pwr_prod_s;
    logic [15:0]        cur_r, pwr_r;

    assign cur_prod_s  = $signed({{18{shunt_r[15]}}, shunt_r}) * $signed({18'd0, cal_r});
    assign cur_shift_s = cur_prod_s[33:12];
    assign cur_abs_s   = cur_r[15] ? (17'd0 - {1'b1, cur_r}) : {1'b0, cur_r};
    assign pwr_prod_s  = {13'd0, cur_abs_s} * {17'd0, bus_r[15:3]};

    // Saturating current and power registers, one clock behind their operands.
    always_ff @(posedge clock) begin
        if (rst) begin
            cur_r <= 16'h0000;
            pwr_r <= 16'h0000;
        end else begin
            if (cur_shift_s > 22'sd32767) begin
                cur_r <= 16'h7FFF;
            end else if (cur_shift_s < -22'sd32768) begin
                cur_r <= 16'h8000;
            end else begin
                cur_r <= cur_shift_s[15:0];
            end
            pwr_r <= (pwr_prod_s[29:28] != 2'b00) ? 16'hFFFF : pwr_prod_s[27:12];
        end
    end

    assign cur_val_s = cur_r;
    assign pwr_val_s = pwr_r;
`else
    assign cur_val_s = 16'h0000;
    assign pwr_val_s = 16'h0000;
`endif

    // Read mux feeding the read snapshot.
    always_comb begin
        case (ptr_r)
            3'd0:    rd_val_s = cfg_r;
            3'd1:    rd_val_s = shunt_r;
            3'd2:    rd_val_s = bus_r;
            3'd3:    rd_val_s = pwr_val_s;
            3'd4:    rd_val_s = cur_val_s;
            3'd5:    rd_val_s = cal_r;
            default: rd_val_s = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_ina219_i2c_model.sv
// Self-checking bench for ina219_i2c_model: bit-banged I2C master, vector table and scoreboard queue.
module tb_ina219_i2c_model;
    localparam int Q = 6;
`ifdef INA219_CALC_EN
    localparam logic [15:0] CALC_WANT = 16'h03E8;
`else
    localparam logic [15:0] CALC_WANT = 16'h0000;
`endif

    logic        clock = 1'b0;
    logic        rst;
    logic        scl;
    logic        m_low;
    logic [15:0] tv, ts;
    wire         sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;
    always #5 clock = ~clock;

    ina219_i2c_model #(.SLV_ADDR(7'h01), .CFG_RST(16'h399F)) dut (
        .clock(clock), .rst(rst), .sda(sda), .scl(scl),
        .test_in_voltage(tv), .test_in_shunt(ts)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  wp;
        logic [15:0] wd;
        logic [15:0] v;
        logic [15:0] s;
        logic [2:0]  rp;
        logic [15:0] want;
    } vec_t;

    vec_t        vecs[19];
    logic [15:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        m_low = ~b;
        tick(Q); scl = 1'b1;
        tick(Q); s = sda;
        tick(Q); scl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start();
        m_low = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        m_low = 1'b1; tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        m_low = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic s;
        logic [7:0] t;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            t[i] = s;
        end
        clk_bit(~ack, s);
        d = t;
    endtask

    task automatic write_reg(input logic [2:0] p, input logic [15:0] v, input string name);
        logic a;
        i2c_start();
        write_byte(8'h02, a);          check({name, " wr addr ack"}, 16'(a), 16'h0001);
        write_byte({5'd0, p}, a);      check({name, " wr ptr ack"}, 16'(a), 16'h0001);
        write_byte(v[15:8], a);        check({name, " wr msb ack"}, 16'(a), 16'h0001);
        write_byte(v[7:0], a);         check({name, " wr lsb ack"}, 16'(a), 16'h0001);
        i2c_stop();
    endtask

    task automatic read_data(input logic [15:0] want, input string name);
        logic a;
        logic [7:0] hi, lo;
        exp_q.push_back(want);
        i2c_start();
        write_byte(8'h03, a);          check({name, " rd addr ack"}, 16'(a), 16'h0001);
        read_byte(1'b1, hi);
        read_byte(1'b0, lo);
        i2c_stop();
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got %h", name, {hi, lo});
        end else begin
            check({name, " data"}, {hi, lo}, exp_q.pop_front());
        end
    endtask

    task automatic read_reg(input logic [2:0] p, input logic [15:0] want, input string name,
                            input logic rs);
        logic a;
        i2c_start();
        write_byte(8'h02, a);          check({name, " ptr addr ack"}, 16'(a), 16'h0001);
        write_byte({5'd0, p}, a);      check({name, " ptr ack"}, 16'(a), 16'h0001);
        if (!rs) i2c_stop();
        read_data(want, name);
    endtask

    initial begin
        logic a, s;
        logic [7:0] b0, b1, b2;

        // wr, wp, wd, voltage, shunt, rp, expected read
        vecs[0]  = '{1'b0, 3'd0, 16'h0000, 16'd0,    16'h0000, 3'd0, 16'h399F};
        vecs[1]  = '{1'b0, 3'd0, 16'h0000, 16'd0,    16'h0000, 3'd2, 16'h0002};
        vecs[2]  = '{1'b0, 3'd0, 16'h0000, 16'd8000, 16'h0000, 3'd2, 16'hFA02};
        vecs[3]  = '{1'b0, 3'd0, 16'h0000, 16'd0,    16'h5DC0, 3'd1, 16'h5DC0};
        vecs[4]  = '{1'b0, 3'd0, 16'h0000, 16'd8000, 16'h5DC0, 3'd2, 16'hFA02};
        vecs[5]  = '{1'b1, 3'd0, 16'h3155, 16'd0,    16'h5DC0, 3'd1, 16'h3E80};
        vecs[6]  = '{1'b0, 3'd0, 16'h0000, 16'd5000, 16'h5DC0, 3'd2, 16'h9C43};
        vecs[7]  = '{1'b1, 3'd0, 16'h399F, 16'd0,    16'h8AD0, 3'd1, 16'h8AD0};
        vecs[8]  = '{1'b1, 3'd0, 16'h199F, 16'd5000, 16'h0000, 3'd2, 16'h7D03};
        vecs[9]  = '{1'b1, 3'd0, 16'h399F, 16'd0,    16'h8000, 3'd1, 16'h8300};
        vecs[10] = '{1'b1, 3'd0, 16'h219F, 16'd0,    16'hEC78, 3'd1, 16'hF060};
        vecs[11] = '{1'b1, 3'd0, 16'h7FFF, 16'd0,    16'h0000, 3'd0, 16'h7FFF};
        vecs[12] = '{1'b1, 3'd5, 16'h1235, 16'd0,    16'h0000, 3'd5, 16'h1234};
        vecs[13] = '{1'b1, 3'd1, 16'hFFFF, 16'd0,    16'h0064, 3'd1, 16'h0064};
        vecs[14] = '{1'b1, 3'd7, 16'h1234, 16'd0,    16'h0000, 3'd6, 16'h0000};
        vecs[15] = '{1'b1, 3'd5, 16'h1000, 16'd0,    16'h03E8, 3'd4, CALC_WANT};
        vecs[16] = '{1'b0, 3'd0, 16'h0000, 16'd4096, 16'h03E8, 3'd3, CALC_WANT};
        vecs[17] = '{1'b1, 3'd0, 16'h8000, 16'd0,    16'h0000, 3'd0, 16'h399F};
        vecs[18] = '{1'b0, 3'd0, 16'h0000, 16'd0,    16'h0000, 3'd5, 16'h0000};

        rst = 1'b1; scl = 1'b1; m_low = 1'b0; tv = 16'd0; ts = 16'd0;
        tick(5);
        rst = 1'b0;
        tick(5);
        check("sda idle after reset", 16'(sda), 16'h0001);

        for (int i = 0; i < 19; i++) begin
            tv = vecs[i].v;
            ts = vecs[i].s;
            tick(8);
            if (vecs[i].wr) write_reg(vecs[i].wp, vecs[i].wd, $sformatf("vec%0d", i));
            read_reg(vecs[i].rp, vecs[i].want, $sformatf("vec%0d", i), (i % 2) == 1);
        end

        // Foreign address 0x02: no ACK and no data driven.
        i2c_start();
        write_byte(8'h04, a);  check("foreign addr nack", 16'(a), 16'h0000);
        write_byte(8'h00, a);  check("foreign byte nack", 16'(a), 16'h0000);
        i2c_stop();
        i2c_start();
        write_byte(8'h05, a);  check("foreign rd nack", 16'(a), 16'h0000);
        read_byte(1'b0, b0);   check("foreign rd sda released", 16'(b0), 16'h00FF);
        i2c_stop();

        // Extra bytes after the LSB are acknowledged and discarded.
        i2c_start();
        write_byte(8'h02, a);  check("extra addr ack", 16'(a), 16'h0001);
        write_byte(8'h05, a);  check("extra ptr ack", 16'(a), 16'h0001);
        write_byte(8'h11, a);  check("extra msb ack", 16'(a), 16'h0001);
        write_byte(8'h22, a);  check("extra lsb ack", 16'(a), 16'h0001);
        write_byte(8'h33, a);  check("extra byte3 ack", 16'(a), 16'h0001);
        write_byte(8'h44, a);  check("extra byte4 ack", 16'(a), 16'h0001);
        i2c_stop();
        read_reg(3'd5, 16'h1122, "extra cal", 1'b0);

        // Master ACK after the LSB restarts the word from its MSB.
        i2c_start();
        write_byte(8'h02, a);  check("cont addr ack", 16'(a), 16'h0001);
        write_byte(8'h00, a);  check("cont ptr ack", 16'(a), 16'h0001);
        i2c_start();
        write_byte(8'h03, a);  check("cont rd addr ack", 16'(a), 16'h0001);
        exp_q.push_back(16'h0039); exp_q.push_back(16'h009F); exp_q.push_back(16'h0039);
        read_byte(1'b1, b0);
        read_byte(1'b1, b1);
        read_byte(1'b0, b2);
        i2c_stop();
        check("cont byte0", {8'h00, b0}, exp_q.pop_front());
        check("cont byte1", {8'h00, b1}, exp_q.pop_front());
        check("cont byte2", {8'h00, b2}, exp_q.pop_front());

        // Reset while the slave drives read data.
        i2c_start();
        write_byte(8'h02, a);
        write_byte(8'h05, a);
        i2c_stop();
        i2c_start();
        write_byte(8'h03, a);  check("rstrd addr ack", 16'(a), 16'h0001);
        check("rstrd slave driving", 16'(sda), 16'h0000);
        rst = 1'b1; tick(2); rst = 1'b0; tick(1);
        check("rstrd sda released", 16'(sda), 16'h0001);
        i2c_stop();
        read_data(16'h399F, "rstrd ptr cleared");
        read_reg(3'd5, 16'h0000, "rstrd cal cleared", 1'b1);

        // Reset in the middle of the LSB aborts the write.
        i2c_start();
        write_byte(8'h02, a);
        write_byte(8'h00, a);
        write_byte(8'h31, a);
        for (int i = 0; i < 4; i++) clk_bit(1'b0, s);
        rst = 1'b1; tick(2); rst = 1'b0; tick(2);
        i2c_stop();
        read_reg(3'd0, 16'h399F, "rstwr no commit", 1'b0);

        check("scoreboard drained", 16'(exp_q.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
